// File: rtl/vram_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : vram_writer_if
// Description : Store-request bus from the vector CPU memory stage into the
//               VRAM writer. Valid/ready handshake carrying a word address,
//               a LANES-byte data vector and a per-lane byte enable.
//               master : CPU side   (drives valid/addr/data/mask)
//               slave  : VRAM side  (drives ready)
// Revision    : 1.0  initial release
// ============================================================================
interface vram_writer_if #(
    parameter int LANES  = 6,
    parameter int ADDR_W = 14
);
    logic                 wr_valid;
    logic                 wr_ready;
    logic [ADDR_W-1:0]    wr_addr;
    logic [LANES*8-1:0]   wr_data;   // lane 0 occupies bits [7:0]
    logic [LANES-1:0]     wr_mask;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_mask,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_mask,
        output wr_ready
    );
endinterface
`default_nettype wire

// File: rtl/vram_writer.sv
`default_nettype none
// ============================================================================
// Module      : vram_writer
// Description : Frame-buffer owner feeding the VGA output stage. Buffers
//               masked byte-vector stores in a small FIFO and commits at most
//               one word per cycle, optionally only during vertical blank.
//               Also performs a hardware full-screen clear.
// Ports       : clk, rst_n           clock / async active-low reset
//               wr (slave modport)   store request handshake
//               vblank_gate_en       restrict commits to vblank_i = 1
//               vblank_i             vertical blank (synchronous to clk)
//               clear_req/clear_color start a full clear with a fill byte
//               busy                 FIFO non-empty or clear running
//               err_oob / err_clr    sticky out-of-range drop flag / clear
//               vram_o               frame-buffer contents
// Revision    : 1.0  initial release
// ============================================================================
module vram_writer #(
    parameter int LANES      = 6,
    parameter int DEPTH      = 10924,
    parameter int ADDR_W     = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    vram_writer_if.slave           wr,
    input  wire logic              vblank_gate_en,
    input  wire logic              vblank_i,
    input  wire logic              clear_req,
    input  wire logic [7:0]        clear_color,
    output logic                   busy,
    output logic                   err_oob,
    input  wire logic              err_clr,
    output logic [LANES*8-1:0]     vram_o [DEPTH]
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_W-1:0]     r_clr_addr;
    logic [7:0]            r_clr_color;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_busy;
    logic                  r_err_oob;

    logic [ADDR_W-1:0]     r_fifo_addr [FIFO_DEPTH];
    logic [LANES*8-1:0]    r_fifo_data [FIFO_DEPTH];
    logic [LANES-1:0]      r_fifo_mask [FIFO_DEPTH];

    logic                  w_full;
    logic                  w_empty;
    logic                  w_commit_ok;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_start_clear;
    logic                  w_clr_last;
    logic                  w_in_clear_nxt;
    logic                  w_head_oob;
    logic                  w_cmt_we;
    logic                  w_clr_we;
    logic [c_CNT_W-1:0]    w_count_nxt;
    logic [ADDR_W-1:0]     w_head_addr;
    logic [LANES*8-1:0]    w_head_data;
    logic [LANES-1:0]      w_head_mask;

    // Full/empty come from the registered count only, so a pop in the same
    // cycle never opens a slot for a push while full.
    assign w_full      = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign wr.wr_ready = ~w_full;

    assign w_commit_ok = ~vblank_gate_en | vblank_i;
    assign w_push      = wr.wr_valid & ~w_full;

    // A clear request in IDLE takes priority over a pending head.
    assign w_start_clear = (r_state == S_IDLE) & clear_req;
    assign w_pop         = (r_state == S_IDLE) & ~clear_req & ~w_empty & w_commit_ok;

    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];
    assign w_head_mask = r_fifo_mask[r_rd_ptr];

    // Extra bit keeps the compare correct even when DEPTH == 2**ADDR_W.
    assign w_head_oob = ({1'b0, w_head_addr} >= (ADDR_W+1)'(DEPTH));
    assign w_cmt_we   = w_pop & ~w_head_oob;
    assign w_clr_we   = (r_state == S_CLEAR);
    assign w_clr_last = (r_clr_addr == ADDR_W'(DEPTH - 1));

    assign w_count_nxt    = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    assign w_in_clear_nxt = w_start_clear | (w_clr_we & ~w_clr_last);

    // Control state: FSM, clear sequencer, FIFO pointers and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_clr_addr  <= '0;
            r_clr_color <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_err_oob   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clear_req) begin
                        r_state     <= S_CLEAR;
                        r_clr_addr  <= '0;
                        r_clr_color <= clear_color;
                    end
                end
                S_CLEAR: begin
                    if (w_clr_last) begin
                        r_clr_addr <= '0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_clr_addr <= r_clr_addr + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_busy  <= (w_count_nxt != '0) | w_in_clear_nxt;

            // A new drop outranks a simultaneous clear of the flag.
            if (w_pop & w_head_oob) r_err_oob <= 1'b1;
            else if (err_clr)       r_err_oob <= 1'b0;
        end
    end

    // FIFO payload storage; validity is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= wr.wr_addr;
            r_fifo_data[r_wr_ptr] <= wr.wr_data;
            r_fifo_mask[r_wr_ptr] <= wr.wr_mask;
        end
    end

    // Frame buffer. Not reset: a partially completed clear is kept.
    // Clear and commit are mutually exclusive by FSM state.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            vram_o[r_clr_addr] <= {LANES{r_clr_color}};
        end else if (w_cmt_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_head_mask[i]) begin
                    vram_o[w_head_addr][i*8 +: 8] <= w_head_data[i*8 +: 8];
                end
            end
        end
    end

    assign busy    = r_busy;
    assign err_oob = r_err_oob;

endmodule
`default_nettype wire

// File: tb/tb_vram_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_writer
// Description : Directed testbench for vram_writer. Expected frame-buffer
//               words are queued with the cycle at which they must be
//               visible; a monitor pops and compares them on falling edges.
//               Flag outputs are compared directly by the stimulus process.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vram_writer;

    localparam int LANES      = 6;
    localparam int DEPTH      = 10924;
    localparam int ADDR_W     = 14;
    localparam int FIFO_DEPTH = 4;
    localparam logic [47:0] C3C = {6{8'h3C}};
    localparam logic [47:0] C5A = {6{8'h5A}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vblank_gate_en, vblank_i, clear_req, err_clr;
    logic [7:0] clear_color;
    logic busy, err_oob;
    logic [LANES*8-1:0] vram [DEPTH];

    vram_writer_if #(.LANES(LANES), .ADDR_W(ADDR_W)) wr_if ();

    vram_writer #(
        .LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr             (wr_if),
        .vblank_gate_en (vblank_gate_en),
        .vblank_i       (vblank_i),
        .clear_req      (clear_req),
        .clear_color    (clear_color),
        .busy           (busy),
        .err_oob        (err_oob),
        .err_clr        (err_clr),
        .vram_o         (vram)
    );

    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    typedef struct {
        int          due;
        int          addr;
        logic [47:0] val;
    } exp_t;

    exp_t sbq[$];

    task automatic sb_push(input int due, input int addr, input logic [47:0] val);
        exp_t e;
        e.due = due; e.addr = addr; e.val = val;
        sbq.push_back(e);
    endtask

    // Monitor: compare every expected word whose visibility cycle has come.
    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            chk($sformatf("vram[%0d]", e.addr), 64'(vram[e.addr]), 64'(e.val));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input int addr, input logic [47:0] d, input logic [5:0] m);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = ADDR_W'(addr);
        wr_if.wr_data  = d;
        wr_if.wr_mask  = m;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired (cyc %0d)", cyc);
        $fatal(1);
    end

    logic [47:0] bp_val [5];
    int c, v, nb, guard;

    initial begin
        bp_val[0] = 48'h101010101010; bp_val[1] = 48'h202020202020;
        bp_val[2] = 48'h303030303030; bp_val[3] = 48'h404040404040;
        bp_val[4] = 48'h505050505050;
        wr_if.wr_valid = 1'b0; wr_if.wr_addr = '0; wr_if.wr_data = '0; wr_if.wr_mask = '0;
        vblank_gate_en = 1'b0; vblank_i = 1'b0; clear_req = 1'b0;
        clear_color = 8'h00; err_clr = 1'b0;

        // Reset state
        repeat (2) step();
        chk("rst_ready", 64'(wr_if.wr_ready), 64'd1);
        chk("rst_busy",  64'(busy),           64'd0);
        chk("rst_err",   64'(err_oob),        64'd0);
        rst_n = 1'b1;
        step();

        // Single store: visible one edge after acceptance, busy for one cycle
        drive(5, 48'h060504030201, 6'b111111);
        sb_push(cyc + 2, 5, 48'h060504030201);
        step();
        wr_if.wr_valid = 1'b0;
        chk("single_busy_hi",  64'(busy),           64'd1);
        chk("single_ready",    64'(wr_if.wr_ready), 64'd1);
        step();
        chk("single_busy_lo",  64'(busy),           64'd0);

        // Lane mask: only lanes 0 and 2 take the new byte
        drive(5, {6{8'hAA}}, 6'b000101);
        sb_push(cyc + 2, 5, 48'h060504AA02AA);
        step();
        wr_if.wr_valid = 1'b0;
        repeat (2) step();

        // Clear with a coincident store to word 7; store lands after the clear
        c = cyc;
        clear_req = 1'b1; clear_color = 8'h3C;
        drive(7, 48'h112233445566, 6'b111111);
        for (int a = 0; a < DEPTH; a++) sb_push(c + DEPTH + 1, a, C3C);
        sb_push(c + DEPTH + 2, 7, 48'h112233445566);
        step();
        clear_req = 1'b0; clear_color = 8'h00; wr_if.wr_valid = 1'b0;
        nb = 0; guard = 0;
        while (busy && guard < 20000) begin
            nb++;
            // Second request mid-clear must be ignored
            if (nb == 500) begin clear_req = 1'b1; clear_color = 8'h99; end
            else           begin clear_req = 1'b0; clear_color = 8'h00; end
            step();
            guard++;
        end
        clear_req = 1'b0;
        chk("clear_busy_len", 64'(nb), 64'(DEPTH + 1));
        repeat (2) step();

        // Backpressure under a closed vblank gate
        vblank_gate_en = 1'b1; vblank_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(10 + i, bp_val[i], 6'b111111);
            chk($sformatf("bp_ready_%0d", i), 64'(wr_if.wr_ready), (i < 4) ? 64'd1 : 64'd0);
            step();
        end
        wr_if.wr_valid = 1'b0;
        chk("bp_busy", 64'(busy), 64'd1);
        for (int a = 10; a < 14; a++) sb_push(cyc + 1, a, C3C);
        repeat (3) step();
        v = cyc;
        chk("bp_ready_full", 64'(wr_if.wr_ready), 64'd0);
        vblank_i = 1'b1;
        sb_push(v + 1, 10, bp_val[0]); sb_push(v + 1, 11, C3C);
        sb_push(v + 2, 11, bp_val[1]); sb_push(v + 2, 12, C3C);
        sb_push(v + 3, 12, bp_val[2]); sb_push(v + 3, 13, C3C);
        sb_push(v + 4, 13, bp_val[3]); sb_push(v + 5, 14, C3C);
        step();
        chk("bp_ready_back", 64'(wr_if.wr_ready), 64'd1);
        repeat (3) step();
        chk("bp_drained", 64'(busy), 64'd0);
        vblank_gate_en = 1'b0; vblank_i = 1'b0;
        repeat (2) step();

        // Out-of-range store
        drive(DEPTH, 48'hDEADBEEFCAFE, 6'b111111);
        step();
        wr_if.wr_valid = 1'b0;
        chk("oob_before", 64'(err_oob), 64'd0);
        step();
        chk("oob_set", 64'(err_oob), 64'd1);
        sb_push(cyc + 1, 0, C3C);
        sb_push(cyc + 1, DEPTH - 1, C3C);
        repeat (2) step();
        chk("oob_sticky", 64'(err_oob), 64'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("oob_clr", 64'(err_oob), 64'd0);
        drive(DEPTH + 5, 48'h0123456789AB, 6'b111111);
        step();
        wr_if.wr_valid = 1'b0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("oob_set_wins", 64'(err_oob), 64'd1);
        repeat (2) step();

        // Reset after words 0..99 of a new clear have been written
        c = cyc;
        clear_req = 1'b1; clear_color = 8'h5A;
        step();
        clear_req = 1'b0;
        repeat (100) step();
        chk("midclr_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",  64'(busy),           64'd0);
        chk("midrst_ready", 64'(wr_if.wr_ready), 64'd1);
        chk("midrst_err",   64'(err_oob),        64'd0);
        sb_push(cyc + 1, 0, C5A);   sb_push(cyc + 1, 7, C5A);
        sb_push(cyc + 1, 99, C5A);  sb_push(cyc + 1, 100, C3C);
        sb_push(cyc + 1, 101, C3C); sb_push(cyc + 1, 13, C5A);
        sb_push(cyc + 1, DEPTH - 1, C3C);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("post_rst_busy", 64'(busy), 64'd0);
        sb_push(cyc + 1, 100, C3C);

        guard = 0;
        while (sbq.size() > 0 && guard < 100) begin step(); guard++; end
        chk("sb_drain", 64'(sbq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vram_writer.md
Name: vram_writer

Overview:
- Upstream feeder for the VGA output stage: owns the frame-buffer storage and drives the VGA stage's `vram_i` array.
- Accepts masked 6-lane byte-vector stores from the vector CPU memory stage through a valid/ready handshake, buffered in a small FIFO.
- Commits at most one 48-bit word per cycle.
- Provides a hardware full-screen clear and an optional vertical-blank write gate to avoid tearing.

Parameters:
- LANES, 6, bytes per VRAM word (vector width).
- DEPTH, 10924, number of VRAM words.
- ADDR_W, 14, word-address width; must satisfy 2^ADDR_W >= DEPTH.
- FIFO_DEPTH, 4, store-request buffer entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, same domain as the CPU.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  store request valid.
- wr_ready  out  1  FIFO can accept a request.
- wr_addr  in  ADDR_W  target word address.
- wr_data  in  LANES x 8  store data; lane 0 = byte 0.
- wr_mask  in  LANES  per-lane byte enable.
- vblank_gate_en  in  1  when 1, commits occur only while vblank_i = 1.
- vblank_i  in  1  vertical-blank indicator, already synchronised to clk.
- clear_req  in  1  single-cycle pulse: start a full clear.
- clear_color  in  8  byte value written to every lane during a clear; sampled on the clear_req cycle.
- busy  out  1  FIFO non-empty or clear in progress.
- err_oob  out  1  sticky flag: a request with wr_addr >= DEPTH was dropped.
- err_clr  in  1  clears err_oob.
- vram_o  out  DEPTH x LANES x 8  frame-buffer contents to the VGA stage.

Behaviour:
- Reset, asynchronous on rst_n low:
  - FSM -> IDLE; FIFO empty; clear counter 0.
  - Outputs: wr_ready = 1, busy = 0, err_oob = 0.
  - vram_o storage is not reset; contents are undefined until written or cleared.
- Handshake:
  - A request is accepted on a rising edge with wr_valid & wr_ready.
  - wr_ready = !fifo_full, combinational from registered state only.
  - When full, no push occurs even if a pop happens in the same cycle.
  - Pushes are accepted in every FSM state.
- Commit enable: `commit_ok = !vblank_gate_en | vblank_i`.
- FSM states:
  - IDLE:
    - clear_req -> CLEAR.
    - Else if FIFO non-empty and commit_ok -> pop the head and write it this edge; stay in IDLE.
  - CLEAR:
    - Each cycle write clear_color to all LANES of word clr_addr, then increment clr_addr.
    - After writing word DEPTH-1 -> clr_addr = 0, return to IDLE.
    - Ignores commit_ok. The FIFO does not drain, but it keeps accepting until full.
    - clear_req while in CLEAR is ignored.
  - clear_req and a pending FIFO head in the same IDLE cycle: clear wins; the head stays queued until the clear finishes.
- Commit rules:
  - Only lanes with wr_mask[i] = 1 are updated; the other lanes hold their value.
  - wr_mask = 0 consumes the entry with no change to memory.
  - Head with addr >= DEPTH: popped with no write, err_oob set on the same edge.
  - err_clr and a new OOB event in the same cycle: err_oob ends at 1 (set wins).
- Latency:
  - A request accepted at edge N into an empty FIFO is written at edge N+1 (given commit_ok), and is visible on vram_o after that edge.
  - Throughput: 1 word/cycle.
- Ordering: strict FIFO order, so same-address stores resolve last-write-wins. There is no read-modify-write hazard because lane masking is applied at the memory.
- busy is registered, = (FIFO count != 0) | (state == CLEAR), and updates on the edge that changes either term.
- Reset mid-clear or mid-drain: FSM and FIFO discarded immediately. Memory keeps any words already written (a partial clear is expected).

Test Plan:
- Single store:
  - Stimulus: after reset, wr_addr = 5, wr_data = {01,02,03,04,05,06}, wr_mask = 6'b111111, one valid cycle, gate off.
  - Required: vram_o[5] = {01..06} after the next edge; busy high for exactly 1 cycle; wr_ready stays 1.
- Lane mask:
  - Stimulus: word 5 holds {01..06}; store {AA x6} with mask 6'b000101.
  - Required: word 5 = {AA,02,AA,04,05,06}.
- Backpressure and vblank gate:
  - Stimulus: vblank_gate_en = 1, vblank_i = 0; drive 5 back-to-back stores.
  - Required: 4 accepted, wr_ready = 0 on the 5th; no memory change.
  - Then raise vblank_i: the 4 entries commit on 4 consecutive edges in order, and wr_ready returns to 1 after the first pop.
- Clear:
  - Stimulus: clear_req with clear_color = 8'h3C, and a store to addr 7 queued in the same cycle.
  - Required: busy for 10924+1 cycles; every word = {3C x6}; then word 7 gets the store value.
  - A second clear_req mid-clear has no effect.
- Out of range:
  - Stimulus: store to addr 10924.
  - Required: no word changes, err_oob = 1 and sticky.
  - err_clr alone -> 0; err_clr coincident with another OOB store -> remains 1.
- Reset mid-clear:
  - Stimulus: assert rst_n = 0 at clear cycle 100.
  - Required: busy = 0 and wr_ready = 1 immediately (asynchronously); words 0..99 = clear value; word 100 onward unchanged.
